// File: rtl/spi_cmd_master_pkg.sv
// rtl/spi_cmd_master_pkg.sv - shared constants, FSM states and helpers for spi_cmd_master
//
// Contents:
//   CMD_LED / CMD_BOOT   command bytes understood by the shield's command slave
//   FRAME_BYTES/BITS     longest frame the master can send (CMD, ADDR, DATA[31:0])
//   LED_*                bit map of the LED-control operand carried in ADDR
//   state_t              frame sequencer states
//   norm_len             maps a raw LEN request onto the byte count actually sent
//   last_bit_idx         index of the final bit of an N-byte frame
package spi_cmd_master_pkg;

    localparam logic [7:0] CMD_LED  = 8'h01;
    localparam logic [7:0] CMD_BOOT = 8'h02;

    localparam int FRAME_BYTES = 6;
    localparam int FRAME_BITS  = 8 * FRAME_BYTES;

    // LED operand: [1:0] enables {G,R}, [3:2] values {G,R}
    localparam int LED_EN_R  = 0;
    localparam int LED_EN_G  = 1;
    localparam int LED_VAL_R = 2;
    localparam int LED_VAL_G = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // A zero or oversize request means "send the whole frame".
    function automatic logic [2:0] norm_len(input logic [2:0] len, input int max_bytes);
        if (len == 3'd0 || int'(len) > max_bytes) begin
            return 3'(max_bytes);
        end
        return len;
    endfunction

    function automatic logic [5:0] last_bit_idx(input logic [2:0] n_bytes);
        return {n_bytes, 3'b000} - 6'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// rtl/spi_cmd_master_if.sv - host request/status bundle plus SPI pins for spi_cmd_master
//
// Host side : START, LEN[2:0], CMD[7:0], ADDR[7:0], DATA[31:0] (requests)
//             BUSY, DONE, RDATA[8*MAX_BYTES-1:0]                (status / captured MISO)
// SPI side  : SCLK, MOSI, SS (driven by the master), MISO (driven by the slave)
// modport master : the spi_cmd_master block
// modport slave  : whoever drives requests and the MISO line
interface spi_cmd_master_if #(
    parameter int MAX_BYTES = 6
);
    logic                     START;
    logic [2:0]               LEN;
    logic [7:0]               CMD;
    logic [7:0]               ADDR;
    logic [31:0]              DATA;
    logic                     BUSY;
    logic                     DONE;
    logic [8*MAX_BYTES-1:0]   RDATA;
    logic                     SCLK;
    logic                     MOSI;
    logic                     MISO;
    logic                     SS;

    modport master (
        input  START, LEN, CMD, ADDR, DATA, MISO,
        output BUSY, DONE, RDATA, SCLK, MOSI, SS
    );

    modport slave (
        output START, LEN, CMD, ADDR, DATA, MISO,
        input  BUSY, DONE, RDATA, SCLK, MOSI, SS
    );

endinterface

// File: rtl/spi_cmd_master_clk_tick.sv
// rtl/spi_cmd_master_clk_tick.sv - SCLK half-period divider and edge strobes
//
// Ports:
//   CLK, RST_N  system clock, async active-low reset
//   run         divider runs while high; cleared (and SCLK parked low) when low
//   shift_en    SCLK toggles on ticks only while high
//   tick        one CLK pulse at the end of every CLK_DIV-cycle half-period
//   rise_tick   tick on which SCLK goes high
//   fall_tick   tick on which SCLK goes low
//   sclk        registered SPI clock
module spi_cmd_master_clk_tick #(
    parameter int CLK_DIV = 50
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic run,
    input  logic shift_en,
    output logic tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    logic [7:0] div_cnt;
    logic       sclk_q;

    assign tick      = run && (div_cnt == 8'(CLK_DIV - 1));
    assign rise_tick = tick && shift_en && !sclk_q;
    assign fall_tick = tick && shift_en && sclk_q;
    assign sclk      = sclk_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            if (shift_en) begin
                sclk_q <= ~sclk_q;
            end
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI mode-0 master sending one CMD/ADDR/DATA frame per START
//
// Parameters:
//   CLK_DIV    CLK cycles per SCLK half-period (2..255)
//   MAX_BYTES  frame length cap and RDATA width / 8
// Ports:
//   CLK, RST_N  system clock, async active-low reset
//   bus         spi_cmd_master_if.master: START/LEN/CMD/ADDR/DATA in,
//               BUSY/DONE/RDATA out, SCLK/MOSI/SS out, MISO in
// Frame: SETUP (1 half-period) -> SHIFT (16*N) -> HOLD (1) -> GAP (2, SS high).
module spi_cmd_master
    import spi_cmd_master_pkg::*;
#(
    parameter int CLK_DIV   = 50,
    parameter int MAX_BYTES = FRAME_BYTES
) (
    input  logic                CLK,
    input  logic                RST_N,
    spi_cmd_master_if.master    bus
);

    localparam int RW = 8 * MAX_BYTES;

    state_t                  state_q;
    state_t                  state_d;
    logic                    done_set;
    logic                    done_q;
    logic                    ss_q;
    logic [FRAME_BITS-1:0]   tx_sr;
    logic [RW-1:0]           rdata_q;
    logic [5:0]              bit_cnt;
    logic [5:0]              last_bit;
    logic [5:0]              rx_idx;
    logic                    gap_q;
    logic                    start_ok;

    logic                    tick;
    logic                    rise_tick;
    logic                    fall_tick;
    logic                    sclk;

    spi_cmd_master_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_tick (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .run       (state_q != ST_IDLE),
        .shift_en  (state_q == ST_SHIFT),
        .tick      (tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sclk      (sclk)
    );

    assign start_ok = (state_q == ST_IDLE) && bus.START;

    // bit_cnt counts completed falling edges, so during a rising tick it is
    // the index of the bit being received; first bit lands in RDATA's MSB.
    assign rx_idx = 6'(RW - 1) - bit_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE:  if (bus.START) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (fall_tick && bit_cnt == last_bit) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_GAP;
            ST_GAP: begin
                if (tick && gap_q) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // MOSI is the MSB of tx_sr: loading the frame presents bit 47 before the
    // first rising edge, each falling tick shifts the next bit up, and
    // clearing the register at the end of HOLD parks MOSI low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_sr    <= '0;
            rdata_q  <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            gap_q    <= 1'b0;
            ss_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_set;
            if (start_ok) begin
                tx_sr    <= {bus.CMD, bus.ADDR, bus.DATA};
                last_bit <= last_bit_idx(norm_len(bus.LEN, MAX_BYTES));
                rdata_q  <= '0;
                bit_cnt  <= '0;
                gap_q    <= 1'b0;
                ss_q     <= 1'b0;
            end
            if (rise_tick) begin
                rdata_q[rx_idx] <= bus.MISO;
            end
            if (fall_tick) begin
                tx_sr   <= tx_sr << 1;
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (state_q == ST_HOLD && tick) begin
                ss_q  <= 1'b1;
                tx_sr <= '0;
            end
            // GAP spans two half-periods; gap_q marks the second one.
            if (state_q == ST_GAP && tick) begin
                gap_q <= ~gap_q;
            end
        end
    end

    assign bus.BUSY  = (state_q != ST_IDLE);
    assign bus.DONE  = done_q;
    assign bus.RDATA = rdata_q;
    assign bus.SCLK  = sclk;
    assign bus.MOSI  = tx_sr[FRAME_BITS-1];
    assign bus.SS    = ss_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb/tb_spi_cmd_master.sv - scoreboard bench for spi_cmd_master
module tb_spi_cmd_master;
    import spi_cmd_master_pkg::*;

    localparam int          CLK_DIV = 4;
    localparam logic [47:0] PAT     = 48'h5A3C_9617_E2D4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    spi_cmd_master_if #(.MAX_BYTES(6)) bus ();

    spi_cmd_master #(
        .CLK_DIV   (CLK_DIV),
        .MAX_BYTES (6)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        logic [47:0] mosi;
        int          nb;
        logic [47:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave side: MISO source, MOSI monitor, command decode
    logic        loop_en = 1'b0;
    logic [47:0] pat_v   = PAT;
    logic [47:0] mon_bits = '0;
    int          mon_rises = 0;
    logic [15:0] w16;
    logic        pat_bit;
    logic        led_g_en = 1'b0, led_r_en = 1'b0, led_g = 1'b0, led_r = 1'b0;
    logic        boot_seen = 1'b0;

    assign pat_bit  = (mon_rises < 48) ? pat_v[6'(47 - mon_rises)] : 1'b0;
    assign bus.MISO = loop_en ? bus.MOSI : pat_bit;

    initial begin
        forever begin
            @(negedge bus.SS or posedge bus.SCLK);
            if (!bus.SCLK) begin
                mon_bits  = '0;
                mon_rises = 0;
            end else if (!bus.SS) begin
                w16 = {mon_bits[14:0], bus.MOSI};
                if (mon_rises == 15) begin
                    if (w16[15:8] == 8'h01) begin
                        led_r_en = w16[0];
                        led_g_en = w16[1];
                        led_r    = w16[2];
                        led_g    = w16[3];
                    end
                    if (w16[15:8] == 8'h02) boot_seen = 1'b1;
                end
                mon_bits  = {mon_bits[46:0], bus.MOSI};
                mon_rises = mon_rises + 1;
            end
        end
    end

    // ---------------- scoreboard consumer, sampled on the falling CLK edge
    int busy_cnt = 0, ss_low_cnt = 0, ss_hi_run = 0, last_gap = 0, done_seen = 0;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                busy_cnt   = 0;
                ss_low_cnt = 0;
            end else begin
                if (bus.BUSY) busy_cnt++;
                if (!bus.SS) begin
                    if (ss_hi_run > 0) last_gap = ss_hi_run;
                    ss_hi_run = 0;
                    ss_low_cnt++;
                end else begin
                    ss_hi_run++;
                end
                if (bus.DONE) begin
                    done_seen++;
                    chk("busy_low_at_done", bus.BUSY, 0);
                    chk("exp_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur_e = exp_q.pop_front();
                        chk("rdata", bus.RDATA, cur_e.rdata);
                        chk("mosi_bits", mon_bits, cur_e.mosi);
                        chk("sclk_rises", mon_rises, 8 * cur_e.nb);
                        chk("busy_cycles", busy_cnt, (16 * cur_e.nb + 4) * CLK_DIV);
                        chk("ss_low_cycles", ss_low_cnt, (16 * cur_e.nb + 2) * CLK_DIV);
                    end
                    busy_cnt   = 0;
                    ss_low_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus
    function automatic exp_t make_exp(input logic [2:0] len, input logic [7:0] c,
                                      input logic [7:0] a, input logic [31:0] d,
                                      input logic lp);
        exp_t        e;
        int          nb;
        logic [47:0] fr;
        logic [47:0] mask;
        nb     = (len == 3'd0 || len > 3'd6) ? 6 : int'(len);
        fr     = {c, a, d};
        mask   = '1;
        mask   = mask << (48 - 8 * nb);
        e.nb   = nb;
        e.mosi = fr >> (48 - 8 * nb);
        e.rdata = (lp ? fr : pat_v) & mask;
        return e;
    endfunction

    task automatic launch(input logic [2:0] len, input logic [7:0] c, input logic [7:0] a,
                          input logic [31:0] d, input logic lp);
        @(negedge CLK);
        loop_en  = lp;
        bus.LEN  = len;
        bus.CMD  = c;
        bus.ADDR = a;
        bus.DATA = d;
        bus.START = 1'b1;
        exp_q.push_back(make_exp(len, c, a, d, lp));
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            @(negedge CLK);
            i++;
        end
        chk(tag, exp_q.size(), 0);
        @(negedge CLK);
    endtask

    initial begin
        int i;
        int d0;
        bus.START = 1'b0;
        bus.LEN   = '0;
        bus.CMD   = '0;
        bus.ADDR  = '0;
        bus.DATA  = '0;
        RST_N     = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_ss", bus.SS, 1);
        chk("rst_sclk", bus.SCLK, 0);
        chk("rst_mosi", bus.MOSI, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_rdata", bus.RDATA, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // LED command, two bytes, pattern on MISO
        launch(3'd2, 8'h01, 8'h0F, 32'h0, 1'b0);
        wait_drain("t1_drain");
        chk("t1_leds", {led_g_en, led_r_en, led_g, led_r}, 4'b1111);
        repeat (50) @(negedge CLK);
        chk("t1_rdata_hold", bus.RDATA, 48'h5A3C_0000_0000);

        // full frame, loopback
        launch(3'd6, 8'h02, 8'h01, 32'hDEAD_BEEF, 1'b1);
        wait_drain("t2_drain");
        chk("t2_rdata_const", bus.RDATA, 48'h0201_DEAD_BEEF);
        chk("t2_boot_seen", boot_seen, 1);

        // LEN 0 and 7 behave as 6
        launch(3'd0, 8'h02, 8'h01, 32'hDEAD_BEEF, 1'b1);
        wait_drain("t3_len0_drain");
        chk("t3_len0_rdata", bus.RDATA, 48'h0201_DEAD_BEEF);
        launch(3'd7, 8'h02, 8'h01, 32'hDEAD_BEEF, 1'b1);
        wait_drain("t3_len7_drain");
        chk("t3_len7_rdata", bus.RDATA, 48'h0201_DEAD_BEEF);

        // START and operand changes while busy
        launch(3'd6, 8'hA1, 8'h5E, 32'h1234_5678, 1'b0);
        repeat (60) @(negedge CLK);
        bus.DATA  = 32'hFFFF_FFFF;
        bus.CMD   = 8'h00;
        bus.LEN   = 3'd1;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        wait_drain("t4_drain");
        repeat (20) @(negedge CLK);
        chk("t4_no_extra_frame", bus.BUSY, 0);

        // START held high: back-to-back frames
        @(negedge CLK);
        loop_en   = 1'b1;
        bus.LEN   = 3'd1;
        bus.CMD   = 8'h3C;
        bus.ADDR  = 8'h00;
        bus.DATA  = 32'h0;
        bus.START = 1'b1;
        exp_q.push_back(make_exp(3'd1, 8'h3C, 8'h00, 32'h0, 1'b1));
        i = 0;
        while (!bus.DONE && i < 2000) begin
            @(negedge CLK);
            i++;
        end
        chk("b2b_first_done", bus.DONE, 1);
        bus.CMD = 8'hC3;
        exp_q.push_back(make_exp(3'd1, 8'hC3, 8'h00, 32'h0, 1'b1));
        @(negedge CLK);
        bus.START = 1'b0;
        chk("b2b_restart_busy", bus.BUSY, 1);
        wait_drain("b2b_drain");
        chk("b2b_gap_cycles", last_gap, 2 * CLK_DIV + 1);

        // async reset mid-frame
        launch(3'd6, 8'h77, 8'h88, 32'h99AA_BBCC, 1'b1);
        i = 0;
        while (mon_rises < 20 && i < 2000) begin
            @(negedge CLK);
            i++;
        end
        chk("t5_reached_bit20", mon_rises >= 20, 1);
        #1 RST_N = 1'b0;
        #1;
        chk("t5_ss_async", bus.SS, 1);
        chk("t5_sclk_async", bus.SCLK, 0);
        chk("t5_busy_async", bus.BUSY, 0);
        exp_q.delete();
        d0 = done_seen;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (40) @(negedge CLK);
        chk("t5_no_done", done_seen - d0, 0);
        chk("t5_rdata_cleared", bus.RDATA, 0);
        launch(3'd6, 8'h11, 8'h22, 32'h3344_5566, 1'b1);
        wait_drain("t5_clean_drain");

        // random frames
        for (int k = 0; k < 6; k++) begin
            launch(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 32'($urandom),
                   1'($urandom_range(0, 1)));
            wait_drain("rnd_drain");
        end

        // slave decode of LED operand 05
        launch(3'd2, 8'h01, 8'h05, 32'hCAFE_F00D, 1'b0);
        wait_drain("t6_drain");
        chk("t6_g_en", led_g_en, 0);
        chk("t6_r_en", led_r_en, 1);
        chk("t6_g", led_g, 0);
        chk("t6_r", led_r, 1);
        // CMD only: slave must not act
        launch(3'd1, 8'h01, 8'h0A, 32'h0, 1'b0);
        wait_drain("t6_len1_drain");
        chk("t6_len1_leds", {led_g_en, led_r_en, led_g, led_r}, 4'b0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
